// File: rtl/dual_sram.sv
// dual_sram: simple dual-port synchronous SRAM, one write and one read port,
// each word packing para_deg lanes of data_width bits.
module dual_sram #(
  parameter int data_width = 8,
  parameter int addr_width = 4,
  parameter int Ram_Depth = 1 << addr_width,
  parameter int para_deg = 4
) (
  input  logic                             clk,
  input  logic                             Mem_Clear,
  input  logic                             Chip_Select,
  input  logic                             En_Write,
  input  logic                             En_Read,
  input  logic [addr_width-1:0]            Write_Addr,
  input  logic [addr_width-1:0]            Read_Addr,
  input  logic [para_deg*data_width-1:0]   Write_Data,
  output logic [para_deg*data_width-1:0]   Read_Data
);
  localparam int word_width = para_deg * data_width;
  logic [word_width-1:0] mem [Ram_Depth];
  logic wr_ok, rd_ok;
  always_comb begin
    wr_ok = int'(Write_Addr) < Ram_Depth;
    rd_ok = int'(Read_Addr) < Ram_Depth;
  end
  // Read-first on same-address collisions falls out of the non-blocking update.
  always_ff @(posedge clk) begin
    if (Mem_Clear) begin
      for (int i = 0; i < Ram_Depth; i++) mem[i] <= '0;
      Read_Data <= '0;
    end else if (Chip_Select) begin
      if (En_Write && wr_ok) mem[Write_Addr] <= Write_Data;
      if (En_Read) Read_Data <= rd_ok ? mem[Read_Addr] : '0;
    end
  end
endmodule

// File: tb/tb_dual_sram.sv
// tb_dual_sram: scoreboard bench for dual_sram against an array-based reference model.
module tb_dual_sram;
  logic clk = 0;
  logic Mem_Clear, Chip_Select, En_Write, En_Read;
  logic [3:0] Write_Addr, Read_Addr;
  logic [31:0] Write_Data, Read_Data;
  int total = 0, bad = 0;
  typedef struct { logic [31:0] v; string n; } exp_t;
  exp_t exp_q[$];
  logic [31:0] ref_mem [16];
  logic [31:0] ref_rd;

  always #5 clk = ~clk;

  dual_sram dut (
    .clk(clk), .Mem_Clear(Mem_Clear), .Chip_Select(Chip_Select),
    .En_Write(En_Write), .En_Read(En_Read), .Write_Addr(Write_Addr),
    .Read_Addr(Read_Addr), .Write_Data(Write_Data), .Read_Data(Read_Data)
  );

  // One bus cycle: drive on the falling edge, update the model at the rising edge.
  task automatic cyc(input logic clr, cs, we, re, input logic [3:0] wa, ra,
                     input logic [31:0] wd, input string nm);
    @(negedge clk);
    Mem_Clear = clr; Chip_Select = cs; En_Write = we; En_Read = re;
    Write_Addr = wa; Read_Addr = ra; Write_Data = wd;
    @(posedge clk);
    if (clr) begin
      foreach (ref_mem[i]) ref_mem[i] = 0;
      ref_rd = 0;
    end else if (cs) begin
      if (re) ref_rd = ref_mem[ra];
      if (we) ref_mem[wa] = wd;
    end
    exp_q.push_back('{ref_rd, nm});
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (Read_Data !== e.v) begin
        bad++;
        $display("FAIL %s: Read_Data=%h expected=%h", e.n, Read_Data, e.v);
      end
    end
  end

  initial begin
    Mem_Clear = 0; Chip_Select = 0; En_Write = 0; En_Read = 0;
    Write_Addr = 0; Read_Addr = 0; Write_Data = 0;
    cyc(1, 0, 0, 0, 0, 0, 0, "reset");
    for (int k = 0; k < 8; k++)
      cyc(0, 1, 1, 0, 4'($urandom_range(15)), 0, $urandom, "arb_write");
    cyc(1, 1, 1, 1, 3, 3, 32'hDEAD_BEEF, "clear");
    cyc(0, 1, 0, 1, 0, 0, 0, "clear_rd0");
    cyc(0, 1, 0, 1, 0, 15, 0, "clear_rd15");
    for (int k = 0; k < 16; k++)
      cyc(0, 1, 1, 0, 4'(k), 0, 32'(k + 1), "fill");
    cyc(0, 1, 0, 1, 0, 0, 0, "fill_rd0");
    cyc(0, 1, 0, 1, 0, 1, 0, "fill_rd1");
    cyc(0, 1, 0, 1, 0, 10, 0, "fill_rd10");
    cyc(0, 1, 0, 0, 0, 4, 0, "rd_en_hold");
    cyc(0, 1, 1, 0, 3, 0, 32'h4433_2211, "lane_wr");
    cyc(0, 1, 0, 1, 0, 3, 0, "lane_rd");
    cyc(0, 1, 1, 0, 5, 0, 32'hAA, "rdw_init");
    cyc(0, 1, 1, 1, 5, 5, 32'hBB, "rdw_old");
    cyc(0, 1, 0, 1, 0, 5, 0, "rdw_new");
    cyc(0, 0, 1, 1, 2, 2, 32'h55, "cs_hold");
    cyc(0, 1, 0, 1, 0, 2, 0, "cs_old");
    cyc(0, 1, 0, 1, 0, 7, 0, "pre_clr_rd7");
    cyc(1, 1, 1, 0, 7, 0, 32'h77, "clr_prio");
    cyc(0, 1, 0, 1, 0, 7, 0, "clr_prio_rd7");
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(40) == 0, $urandom_range(7) != 0, 1'($urandom),
          1'($urandom), 4'($urandom), 4'($urandom), $urandom, "random");
    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dual_sram.md
Name: dual_sram

Overview:
Simple dual-port synchronous SRAM: one write port and one read port, both clocked on a single clock. Each word holds para_deg packed lanes of data_width bits, so one access moves a whole parallel vector. Used as the input/output operand buffers of the Conv1D datapath, with one instance per operand stream.

Parameters:
data_width, 8, bits per lane.
addr_width, 4, address bits for both ports.
Ram_Depth, 1 << addr_width, number of words; must be ≤ 2^addr_width.
para_deg, 4, lanes per word; word width = para_deg*data_width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
Mem_Clear  in  1  reset: synchronous, active-high; also clears memory contents.
Chip_Select  in  1  global enable for both ports.
En_Write  in  1  write enable.
En_Read  in  1  read enable.
Write_Addr  in  addr_width  write word address.
Read_Addr  in  addr_width  read word address.
Write_Data  in  para_deg*data_width  write word; lane i = bits [i*data_width +: data_width].
Read_Data  out  para_deg*data_width  registered read word; same lane packing.

Behaviour:
- Priority at each rising clk: Mem_Clear > Chip_Select gating > write/read.
- Mem_Clear=1: every word of the array <= 0 and Read_Data <= 0 in that cycle.
  - Write and read requests in the same cycle are ignored.
  - Clear takes effect whenever asserted, including mid-operation; state before power-up reset is don't-care.
- Chip_Select=0 with Mem_Clear=0: no write; Read_Data holds its previous value.
- Write: Chip_Select & En_Write & Write_Addr < Ram_Depth -> mem[Write_Addr] <= Write_Data, whole word, all lanes.
  - There are no byte/lane enables.
  - Write_Addr ≥ Ram_Depth: write is dropped.
- Read: Chip_Select & En_Read -> Read_Data <= mem[Read_Addr]. Latency is 1 cycle, with the data valid after the edge that samples Read_Addr.
  - Read_Addr ≥ Ram_Depth: Read_Data <= 0.
  - En_Read=0: Read_Data holds.
- Simultaneous read and write to the same address in the same cycle: read-first. Read_Data gets the old contents; the new data is visible on the next read.
- Read and write to different addresses in the same cycle are fully independent.
- No full/empty concept; addresses do not wrap or auto-increment.
- Read_Data is a pure register output with no combinational path from inputs.

Decomposition:
- No shared package is required.
- Word width para_deg*data_width is a local constant.
- The lane slicing helper (lane i offset = i*data_width) belongs in the Conv1D common package if other blocks need it.
- Single flat module; no sub-module needed. The storage array is an inferred register/RAM array of Ram_Depth words.

Test Plan:
- Clear: assert Mem_Clear for 1 cycle after arbitrary writes, then read addresses 0 and 15 -> Read_Data = 0 both times.
- Fill and read back:
  - Fill: write addr k with lane0 = k+1 and other lanes 0, for k = 0..15.
  - Read addr 0 -> lane0 = 1, one cycle later; read addr 1 -> lane0 = 2; read addr 10 -> lane0 = 11. Lanes 1..3 = 0 in every case.
- Lane packing: write addr 3 with 0x44332211, read addr 3 -> Read_Data[0]=0x11, [1]=0x22, [2]=0x33, [3]=0x44.
- Read-during-write: mem[5]=0xAA; in the same cycle write 0xBB to addr 5 and read addr 5 -> Read_Data = 0xAA; the next read of addr 5 -> 0xBB.
- Chip_Select gating:
  - With Chip_Select=0, write 0x55 to addr 2 and read addr 2 -> Read_Data unchanged.
  - Then set Chip_Select=1 and read addr 2 -> old contents, not 0x55.
- Clear priority: Mem_Clear=1 with En_Write=1 writing 0x77 to addr 7 -> the next read of addr 7 = 0.
